// File: rtl/game_state_writer_if.sv
// Avalon-MM write-only bus between the game state writer (master) and the display register port.
interface game_state_writer_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              chipselect;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;

  modport master (
    output chipselect, write, address, writedata,
    input  waitrequest
  );

  modport slave (
    input  chipselect, write, address, writedata,
    output waitrequest
  );
endinterface

// File: rtl/game_state_writer.sv
// Pushes latest-wins game state snapshots to the display's six registers as one
// Avalon-MM write burst per frame_start, so the display only changes in vertical blank.
module game_state_writer #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int BASE_ADDR = 0,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              upd_valid,
  output logic              upd_ready,
  input  logic [DATA_W-1:0] in_p1_x,
  input  logic [DATA_W-1:0] in_p1_y,
  input  logic [DATA_W-1:0] in_p2_x,
  input  logic [DATA_W-1:0] in_p2_y,
  input  logic [DATA_W-1:0] in_p1_health,
  input  logic [DATA_W-1:0] in_p2_health,
  input  logic              frame_start,
  game_state_writer_if.master bus,
  output logic              busy,
  output logic              overrun,
  output logic [CNT_W-1:0]  frames_sent
);

  typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;

  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);
  localparam logic [5:0][DATA_W-1:0] DEFAULTS = {
    DATA_W'(32'd3), DATA_W'(32'd3), DATA_W'(32'd70),
    DATA_W'(32'd80), DATA_W'(32'd70), DATA_W'(32'd10)
  };

  state_t                  state_r, state_s;
  logic [2:0]              idx_r, idx_s, idx_nxt_s;
  logic [5:0][DATA_W-1:0]  pend_r, pend_s;
  logic [5:0][DATA_W-1:0]  act_r, act_s;
  logic                    pend_flag_r, pend_flag_s;
  logic                    cs_r, cs_s;
  logic                    wr_r, wr_s;
  logic [ADDR_W-1:0]       addr_r, addr_s;
  logic [DATA_W-1:0]       wd_r, wd_s;
  logic                    busy_r, busy_s;
  logic                    overrun_r, overrun_s;
  logic [CNT_W-1:0]        frames_r, frames_s;
  logic [5:0][DATA_W-1:0]  upd_fields_s;

  assign upd_fields_s = {in_p2_health, in_p1_health, in_p2_y, in_p2_x, in_p1_y, in_p1_x};

  // Next-state, capture and bus-output logic; nonblocking registers make a same-cycle
  // update land in PEND while ACT still takes the previous PEND contents.
  always_comb begin
    state_s     = state_r;
    idx_s       = idx_r;
    idx_nxt_s   = idx_r + 3'd1;
    pend_s      = pend_r;
    pend_flag_s = pend_flag_r;
    act_s       = act_r;
    cs_s        = cs_r;
    wr_s        = wr_r;
    addr_s      = addr_r;
    wd_s        = wd_r;
    overrun_s   = overrun_r;
    frames_s    = frames_r;

    if (upd_valid) begin
      pend_s      = upd_fields_s;
      pend_flag_s = 1'b1;
    end else begin
      pend_s      = pend_r;
    end

    case (state_r)
      IDLE: begin
        if (frame_start && pend_flag_r) begin
          state_s     = SEND;
          act_s       = pend_r;
          pend_flag_s = upd_valid;
          idx_s       = 3'd0;
          cs_s        = 1'b1;
          wr_s        = 1'b1;
          addr_s      = BASE_A;
          wd_s        = pend_r[0];
        end else begin
          state_s     = IDLE;
        end
      end
      SEND: begin
        if (frame_start) begin
          overrun_s = 1'b1;
        end else begin
          overrun_s = overrun_r;
        end
        // A beat retires only when the slave is not stalling; otherwise hold address/data.
        if (wr_r && !bus.waitrequest) begin
          if (idx_r == 3'd5) begin
            state_s  = IDLE;
            cs_s     = 1'b0;
            wr_s     = 1'b0;
            frames_s = frames_r + CNT_W'(1'b1);
          end else begin
            idx_s    = idx_nxt_s;
            addr_s   = BASE_A + ADDR_W'(idx_nxt_s);
            wd_s     = act_r[idx_nxt_s];
          end
        end else begin
          state_s = SEND;
        end
      end
      default: begin
        state_s = IDLE;
        cs_s    = 1'b0;
        wr_s    = 1'b0;
      end
    endcase

    busy_s = (state_s == SEND);
  end

  // State and output registers with synchronous reset to the default snapshot.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      idx_r       <= 3'd0;
      pend_r      <= DEFAULTS;
      pend_flag_r <= 1'b1;
      act_r       <= DEFAULTS;
      cs_r        <= 1'b0;
      wr_r        <= 1'b0;
      addr_r      <= BASE_A;
      wd_r        <= '0;
      busy_r      <= 1'b0;
      overrun_r   <= 1'b0;
      frames_r    <= '0;
    end else begin
      state_r     <= state_s;
      idx_r       <= idx_s;
      pend_r      <= pend_s;
      pend_flag_r <= pend_flag_s;
      act_r       <= act_s;
      cs_r        <= cs_s;
      wr_r        <= wr_s;
      addr_r      <= addr_s;
      wd_r        <= wd_s;
      busy_r      <= busy_s;
      overrun_r   <= overrun_s;
      frames_r    <= frames_s;
    end
  end

  assign upd_ready      = 1'b1;
  assign bus.chipselect = cs_r;
  assign bus.write      = wr_r;
  assign bus.address    = addr_r;
  assign bus.writedata  = wd_r;
  assign busy           = busy_r;
  assign overrun        = overrun_r;
  assign frames_sent    = frames_r;

endmodule

// File: tb/tb_game_state_writer.sv
// Table-driven bench for game_state_writer plus hand sequences for overrun and mid-burst reset.
module tb_game_state_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, upd_valid, upd_ready, frame_start, busy, overrun;
  logic [7:0]  in_p1_x, in_p1_y, in_p2_x, in_p2_y, in_p1_health, in_p2_health;
  logic [15:0] frames_sent;

  game_state_writer_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  game_state_writer #(.DATA_W(8), .ADDR_W(4), .BASE_ADDR(0), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .in_p1_x(in_p1_x), .in_p1_y(in_p1_y), .in_p2_x(in_p2_x), .in_p2_y(in_p2_y),
    .in_p1_health(in_p1_health), .in_p2_health(in_p2_health),
    .frame_start(frame_start), .bus(bus),
    .busy(busy), .overrun(overrun), .frames_sent(frames_sent)
  );

  typedef struct {
    logic        uv;
    logic [7:0]  x;
    logic        fs;
    logic        wr;
    logic        ew;
    logic [3:0]  ea;
    logic [7:0]  ed;
    logic [15:0] ef;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int failures = 0;
  logic [7:0] dflt [6] = '{8'd10, 8'd70, 8'd80, 8'd70, 8'd3, 8'd3};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic void add(input logic uv, input logic [7:0] x, input logic fs, input logic wr,
                              input logic ew, input logic [3:0] ea, input logic [7:0] ed,
                              input logic [15:0] ef);
    vec_t v;
    v.uv = uv; v.x = x; v.fs = fs; v.wr = wr;
    v.ew = ew; v.ea = ea; v.ed = ed; v.ef = ef;
    vecs.push_back(v);
  endfunction

  // One clock: drive inputs at negedge, sample 1 time unit after posedge.
  task automatic cycle(input logic rs, input logic uv, input logic [7:0] x, input logic fs,
                       input logic wr);
    @(negedge clk);
    reset = rs; upd_valid = uv; frame_start = fs; bus.waitrequest = wr;
    in_p1_x = x; in_p1_y = x + 8'd1; in_p2_x = x + 8'd2;
    in_p2_y = x + 8'd3; in_p1_health = x + 8'd4; in_p2_health = x + 8'd5;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string name, input logic ew, input logic [3:0] ea,
                            input logic [7:0] ed, input logic [15:0] ef);
    chk({name, ".write"}, {31'd0, bus.write}, {31'd0, ew});
    chk({name, ".cs"}, {31'd0, bus.chipselect}, {31'd0, ew});
    chk({name, ".busy"}, {31'd0, busy}, {31'd0, ew});
    if (ew) begin
      chk({name, ".addr"}, {28'd0, bus.address}, {28'd0, ea});
      chk({name, ".data"}, {24'd0, bus.writedata}, {24'd0, ed});
    end
    chk({name, ".frames"}, {16'd0, frames_sent}, {16'd0, ef});
  endtask

  initial begin
    // Defaults burst, idle frame, latest-wins, waitrequest stall, same-cycle update.
    add(1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 4'd0, 8'd10, 16'd0);
    for (int k = 1; k < 6; k++) add(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 4'(k), dflt[k], 16'd0);
    add(1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 16'd1);
    add(1'b0, 8'd0,  1'b1, 1'b0, 1'b0, 4'd0, 8'd0, 16'd1);
    add(1'b1, 8'd20, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 16'd1);
    add(1'b1, 8'd30, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 16'd1);
    for (int k = 0; k < 6; k++) add(1'b0, 8'd0, (k == 0), 1'b0, 1'b1, 4'(k), 8'(30 + k), 16'd1);
    add(1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 16'd2);
    add(1'b1, 8'd40, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 16'd2);
    add(1'b0, 8'd0,  1'b1, 1'b0, 1'b1, 4'd0, 8'd40, 16'd2);
    add(1'b0, 8'd0,  1'b0, 1'b0, 1'b1, 4'd1, 8'd41, 16'd2);
    add(1'b0, 8'd0,  1'b0, 1'b0, 1'b1, 4'd2, 8'd42, 16'd2);
    for (int k = 0; k < 3; k++) add(1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 4'd2, 8'd42, 16'd2);
    add(1'b0, 8'd0,  1'b0, 1'b0, 1'b1, 4'd3, 8'd43, 16'd2);
    add(1'b0, 8'd0,  1'b0, 1'b0, 1'b1, 4'd4, 8'd44, 16'd2);
    add(1'b0, 8'd0,  1'b0, 1'b0, 1'b1, 4'd5, 8'd45, 16'd2);
    add(1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 16'd3);
    add(1'b1, 8'd50, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 16'd3);
    add(1'b1, 8'd60, 1'b1, 1'b0, 1'b1, 4'd0, 8'd50, 16'd3);
    for (int k = 1; k < 6; k++) add(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 4'(k), 8'(50 + k), 16'd3);
    add(1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 16'd4);
    for (int k = 0; k < 6; k++) add(1'b0, 8'd0, (k == 0), 1'b0, 1'b1, 4'(k), 8'(60 + k), 16'd4);
    add(1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 16'd5);

    reset = 1'b1; upd_valid = 1'b0; frame_start = 1'b0; bus.waitrequest = 1'b0;
    in_p1_x = 8'd0; in_p1_y = 8'd0; in_p2_x = 8'd0; in_p2_y = 8'd0;
    in_p1_health = 8'd0; in_p2_health = 8'd0;
    cycle(1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
    chk("rst.write", {31'd0, bus.write}, 32'd0);
    chk("rst.cs", {31'd0, bus.chipselect}, 32'd0);
    chk("rst.addr", {28'd0, bus.address}, 32'd0);
    chk("rst.data", {24'd0, bus.writedata}, 32'd0);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.overrun", {31'd0, overrun}, 32'd0);
    chk("rst.frames", {16'd0, frames_sent}, 32'd0);
    chk("rst.upd_ready", {31'd0, upd_ready}, 32'd1);
    cycle(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      cycle(1'b0, vecs[i].uv, vecs[i].x, vecs[i].fs, vecs[i].wr);
      check_outs($sformatf("vec%0d", i), vecs[i].ew, vecs[i].ea, vecs[i].ed, vecs[i].ef);
    end
    chk("tbl.overrun", {31'd0, overrun}, 32'd0);

    // frame_start while sending: overrun latches, burst runs to completion.
    cycle(1'b0, 1'b1, 8'd70, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
    check_outs("ovr0", 1'b1, 4'd0, 8'd70, 16'd5);
    cycle(1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
    check_outs("ovr1", 1'b1, 4'd1, 8'd71, 16'd5);
    chk("ovr.flag", {31'd0, overrun}, 32'd1);
    for (int k = 2; k < 6; k++) begin
      cycle(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
      check_outs($sformatf("ovr%0d", k), 1'b1, 4'(k), 8'(70 + k), 16'd5);
    end
    cycle(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    check_outs("ovr.end", 1'b0, 4'd0, 8'd0, 16'd6);
    chk("ovr.sticky", {31'd0, overrun}, 32'd1);

    // Reset while address 3 is on the bus, then the defaults go out on the next frame.
    cycle(1'b0, 1'b1, 8'd80, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
    for (int k = 1; k < 4; k++) cycle(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    check_outs("mid.beat3", 1'b1, 4'd3, 8'd83, 16'd6);
    cycle(1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
    check_outs("mid.rst", 1'b0, 4'd0, 8'd0, 16'd0);
    chk("mid.overrun", {31'd0, overrun}, 32'd0);
    cycle(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    check_outs("mid.idle", 1'b0, 4'd0, 8'd0, 16'd0);
    cycle(1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
    check_outs("dflt0", 1'b1, 4'd0, dflt[0], 16'd0);
    for (int k = 1; k < 6; k++) begin
      cycle(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
      check_outs($sformatf("dflt%0d", k), 1'b1, 4'(k), dflt[k], 16'd0);
    end
    cycle(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    check_outs("dflt.end", 1'b0, 4'd0, 8'd0, 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
